// File: rtl/polar_to_rect_pkg.sv
// polar_to_rect_pkg: widths, CORDIC constants, state type and output rounding for polar_to_rect
package polar_to_rect_pkg;
  localparam int SIZE_DATA = 16;
  localparam int CORDIC_ITERATIONS = 14;
  localparam int GUARD_BITS = 2;
  localparam int DATA_W = SIZE_DATA + 2 * GUARD_BITS;
  localparam int K_W = $clog2(SIZE_DATA);
  localparam logic signed [SIZE_DATA-1:0] CORDIC_INV_GAIN = 16'sh4DBA;
  localparam logic signed [DATA_W-1:0] ATAN_TABLE [SIZE_DATA] = '{
    20'sd32768, 20'sd19344, 20'sd10221, 20'sd5188, 20'sd2604, 20'sd1303, 20'sd652, 20'sd326,
    20'sd163, 20'sd81, 20'sd41, 20'sd20, 20'sd10, 20'sd5, 20'sd3, 20'sd1
  };
  localparam logic signed [DATA_W:0] ROUND_HALF = (DATA_W+1)'(2 ** (GUARD_BITS - 1));
  localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'(2 ** (SIZE_DATA - 1) - 1);
  localparam logic signed [DATA_W:0] SAT_MIN = (DATA_W+1)'(-(2 ** (SIZE_DATA - 1)));
  typedef enum logic [1:0] {IDLE, PRESCALE, ROTATE, DONE} cordic_state_t;
  function automatic logic signed [SIZE_DATA-1:0] round_sat(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] r;
    r = ($signed({v[DATA_W-1], v}) + ROUND_HALF) >>> GUARD_BITS;
    return r > SAT_MAX ? SAT_MAX[SIZE_DATA-1:0] : r < SAT_MIN ? SAT_MIN[SIZE_DATA-1:0] : r[SIZE_DATA-1:0];
  endfunction
endpackage

// File: rtl/polar_to_rect_if.sv
// polar_to_rect_if: valid/ready input (magnitude, phase) and output (I, Q) channels
interface polar_to_rect_if;
  import polar_to_rect_pkg::*;
  logic in_valid;
  logic in_ready;
  logic signed [SIZE_DATA-1:0] magnitude;
  logic signed [SIZE_DATA-1:0] phase;
  logic out_valid;
  logic out_ready;
  logic signed [SIZE_DATA-1:0] data_i;
  logic signed [SIZE_DATA-1:0] data_q;
  modport master(output in_valid, magnitude, phase, out_ready, input in_ready, out_valid, data_i, data_q);
  modport slave(input in_valid, magnitude, phase, out_ready, output in_ready, out_valid, data_i, data_q);
endinterface

// File: rtl/polar_to_rect_cordic_rotate_stage.sv
// cordic_rotate_stage: one combinational CORDIC rotation-mode micro-rotation
module cordic_rotate_stage #(
  parameter int W = 20,
  parameter int KW = 4
) (
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic signed [W-1:0]  z_i,
  input  logic        [KW-1:0] k_i,
  input  logic signed [W-1:0]  atan_i,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic signed [W-1:0]  z_o
);
  logic signed [W-1:0] xs, ys;
  logic neg;
  assign xs = x_i >>> k_i;
  assign ys = y_i >>> k_i;
  assign neg = z_i[W-1];
  assign x_o = neg ? x_i + ys : x_i - ys;
  assign y_o = neg ? y_i - xs : y_i + xs;
  assign z_o = neg ? z_i + atan_i : z_i - atan_i;
endmodule

// File: rtl/polar_to_rect.sv
// polar_to_rect: iterative rotation-mode CORDIC turning (magnitude, phase) into saturated I/Q
module polar_to_rect
  import polar_to_rect_pkg::*;
#(
  parameter int ITERATIONS = CORDIC_ITERATIONS
) (
  input logic clk,
  input logic reset,
  polar_to_rect_if.slave bus
);
  localparam int N = SIZE_DATA;
  localparam int W = DATA_W;
  localparam int G = GUARD_BITS;
  cordic_state_t state_q;
  logic in_ready_q, out_valid_q;
  logic signed [N-1:0] mag_q, phase_q, di_q, dq_q;
  logic signed [W-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic [K_W-1:0] k_q;
  logic signed [2*N-1:0] prod;
  logic signed [W-1:0] x0, x_init, z0;
  logic signed [N-1:0] ph_f;
  logic fold;
  // x0 keeps G fractional guard bits, so shift by N-1-G instead of N-1
  assign prod = mag_q * CORDIC_INV_GAIN;
  assign x0 = W'(prod >>> (N - 1 - G));
  assign fold = phase_q[N-1] ^ phase_q[N-2];
  assign ph_f = fold ? {~phase_q[N-1], phase_q[N-2:0]} : phase_q;
  assign x_init = fold ? -x0 : x0;
  assign z0 = {{G{ph_f[N-1]}}, ph_f, {G{1'b0}}};
  cordic_rotate_stage #(.W(W), .KW(K_W)) u_stage (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .k_i(k_q), .atan_i(ATAN_TABLE[k_q]),
    .x_o(x_d), .y_o(y_d), .z_o(z_d)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      di_q <= '0;
      dq_q <= '0;
      k_q <= '0;
      mag_q <= '0;
      phase_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid && in_ready_q) begin
          mag_q <= bus.magnitude[N-1] ? '0 : bus.magnitude;
          phase_q <= bus.phase;
          in_ready_q <= 1'b0;
          state_q <= PRESCALE;
        end
        PRESCALE: begin
          x_q <= x_init;
          y_q <= '0;
          z_q <= z0;
          k_q <= '0;
          state_q <= ROTATE;
        end
        ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          k_q <= k_q + 1'b1;
          if (k_q == K_W'(ITERATIONS - 1)) begin
            di_q <= round_sat(x_d);
            dq_q <= round_sat(y_d);
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_i = di_q;
  assign bus.data_q = dq_q;
endmodule

// File: tb/tb_polar_to_rect.sv
// tb_polar_to_rect: directed vectors with hand-computed I/Q for polar_to_rect
module tb_polar_to_rect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  polar_to_rect_if bus();
  polar_to_rect dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    tests++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask
  // lat counts posedges from the accept edge (inclusive) until out_valid is seen
  task automatic send(input int mag, input int ph, output int lat);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_wait", int'(bus.in_ready), 1, 0);
    bus.magnitude = 16'(mag);
    bus.phase = 16'(ph);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic vec(input string tag, input int mag, input int ph, input int ei, input int eq);
    int lat;
    send(mag, ph, lat);
    chk({tag, "_valid"}, int'(bus.out_valid), 1, 0);
    chk({tag, "_i"}, int'(bus.data_i), ei, 4);
    chk({tag, "_q"}, int'(bus.data_q), eq, 4);
    pop();
  endtask
  initial begin
    int lat, hold_i, hold_q;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.magnitude = '0;
    bus.phase = '0;
    repeat (3) tick();
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_data_i", int'(bus.data_i), 0, 0);
    chk("rst_data_q", int'(bus.data_q), 0, 0);
    reset = 1'b1;
    tick();
    send(16384, 0, lat);
    chk("latency", lat, 16, 0);
    chk("ph0_i", int'(bus.data_i), 16384, 4);
    chk("ph0_q", int'(bus.data_q), 0, 4);
    pop();
    chk("idle_after_pop", int'(bus.out_valid), 0, 0);
    vec("ph90", 16384, 16'h4000, 0, 16384);
    vec("phm90", 16384, 16'hC000, 0, -16384);
    vec("ph45", 16384, 16'h2000, 11585, 11585);
    vec("phm180", 16384, 16'h8000, -16384, 0);
    vec("sat", 32767, 0, 32767, 0);
    vec("neg_mag", -5, 16'h2000, 0, 0);
    send(12000, 16'h1000, lat);
    chk("bp_i", int'(bus.data_i), 11087, 4);
    chk("bp_q", int'(bus.data_q), 4592, 4);
    hold_i = int'(bus.data_i);
    hold_q = int'(bus.data_q);
    bus.magnitude = 16'd1000;
    bus.phase = 16'h0000;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_i", int'(bus.data_i), hold_i, 0);
      chk("bp_hold_q", int'(bus.data_q), hold_q, 0);
      chk("bp_valid", int'(bus.out_valid), 1, 0);
      chk("bp_in_ready", int'(bus.in_ready), 0, 0);
    end
    bus.in_valid = 1'b0;
    pop();
    chk("bp_one_beat", int'(bus.out_valid), 0, 0);
    chk("bp_idle_ready", int'(bus.in_ready), 1, 0);
    repeat (20) tick();
    chk("bp_no_second", int'(bus.out_valid), 0, 0);
    bus.magnitude = 16'd16384;
    bus.phase = 16'h2000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    chk("abort_valid", int'(bus.out_valid), 0, 0);
    chk("abort_ready", int'(bus.in_ready), 1, 0);
    chk("abort_i", int'(bus.data_i), 0, 0);
    chk("abort_q", int'(bus.data_q), 0, 0);
    reset = 1'b1;
    tick();
    vec("after_abort", 16384, 16'h1555, 14189, 8192);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
